// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: drain FSM states and default data width.
package uart_pkg;

  localparam int DBITS_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_LOAD = 2'd2,
    ST_WAIT = 2'd3
  } drain_state_e;

endpackage : uart_pkg

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. The grant is combinational; only the
// "last served" pointer is stored, and it moves only when the caller says the
// granted transfer was accepted.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // last_q = 1 means requester 1 was served most recently, so requester 0
  // wins the next tie. Resetting to 1 gives req0 the first tie.
  logic last_q;
  logic last_d;

  // Grant decode and pointer next-state.
  // NOTE: every output of an always_comb gets a default first; without it a
  // missed branch would hold its old value and infer a latch.
  always_comb begin
    grant  = 2'b00;
    last_d = last_q;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    if (advance) begin
      last_d = grant[1];
    end
  end

  // Pointer register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule : rr_arb2

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: round-robin merges two byte producers into the TX
// FIFO and drains the FIFO into the transmitter one byte at a time, covering
// the FIFO's one-cycle registered read and the transmitter's start/done pair.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int DBITS = DBITS_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             req0_valid,
  input  logic [DBITS-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [DBITS-1:0] req1_data,
  output logic             req1_ready,
  output logic             fifo_wr_en,
  output logic [DBITS-1:0] fifo_wr_data,
  input  logic             fifo_full,
  output logic             fifo_rd_en,
  input  logic [DBITS-1:0] fifo_rd_data,
  input  logic             fifo_empty,
  output logic             tx_start,
  output logic [DBITS-1:0] tx_data,
  input  logic             tx_done_tick,
  output logic             busy,
  output logic [CNT_W-1:0] bytes_sent
);

  // ---------------------------------------------------------------------------
  // Write side: combinational grant, pointer lives in the arbiter.
  // ---------------------------------------------------------------------------
  logic [1:0] grant;

  // A write happens whenever anyone is asking and the FIFO has room; that is
  // exactly the accepted-transfer condition, so it also advances the pointer.
  assign fifo_wr_en = (req0_valid | req1_valid) & ~fifo_full;
  assign req0_ready = grant[0] & ~fifo_full;
  assign req1_ready = grant[1] & ~fifo_full;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({req1_valid, req0_valid}),
    .advance (fifo_wr_en),
    .grant   (grant)
  );

  // Steer the granted producer's byte onto the FIFO write port; zero when idle.
  always_comb begin
    fifo_wr_data = '0;
    if (grant[1]) begin
      fifo_wr_data = req1_data;
    end else if (grant[0]) begin
      fifo_wr_data = req0_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Drain side: IDLE -> POP -> LOAD -> WAIT -> IDLE, all outputs registered.
  // ---------------------------------------------------------------------------
  drain_state_e     state_q;
  logic             rd_en_q;
  logic             busy_q;
  logic             tx_start_q;
  logic [DBITS-1:0] tx_data_q;
  logic [CNT_W-1:0] bytes_sent_q;

  // Drain FSM with its registered outputs. rd_en is raised on entry to POP so
  // it is high for exactly that state; tx_start is raised on the LOAD edge so
  // it covers exactly the first WAIT cycle. enable is only looked at in IDLE,
  // so dropping it never abandons a byte that has already been popped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rd_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      bytes_sent_q <= '0;
    end else begin
      rd_en_q    <= 1'b0;
      tx_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (enable && !fifo_empty) begin
            state_q <= ST_POP;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_POP: begin
          state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          // fifo_rd_data is valid this cycle, one cycle after the read strobe.
          state_q      <= ST_WAIT;
          tx_data_q    <= fifo_rd_data;
          tx_start_q   <= 1'b1;
          bytes_sent_q <= bytes_sent_q + CNT_W'(1);
        end
        ST_WAIT: begin
          // A done tick coincident with tx_start is accepted here as well.
          if (tx_done_tick) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign busy       = busy_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign bytes_sent = bytes_sent_q;

endmodule : uart_tx_sched

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit-side scheduler for the UART. It arbitrates between two byte producers, using round-robin, and writes the winner into the 16-entry TX FIFO. It drains the FIFO into the UART transmitter one byte at a time, respecting the FIFO's one-cycle registered read latency and the transmitter's start/done handshake. It sits between the producers, the TX FIFO instance and the UART transmitter.

## Interface
- DBITS, 8, data width; must match the FIFO and the transmitter.
- CNT_W, 16, width of the sent-byte counter.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  one clock; reset is synchronous and active-high.
- enable  in  1  permits starting new drains; does not gate writes.
- req0_valid / req1_valid  in  1  producer has a byte.
- req0_data / req1_data  in  DBITS  producer byte.
- req0_ready / req1_ready  out  1  byte accepted this cycle when valid && ready.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_wr_data  out  DBITS  FIFO write data.
- fifo_full  in  1  FIFO full flag.
- fifo_rd_en  out  1  FIFO read strobe.
- fifo_rd_data  in  DBITS  FIFO registered output; valid the cycle after rd_en.
- fifo_empty  in  1  FIFO empty flag.
- tx_start  out  1  one-cycle start pulse to the transmitter.
- tx_data  out  DBITS  byte for the transmitter; held until the next load.
- tx_done_tick  in  1  transmitter finished the current byte.
- busy  out  1  drain FSM not in IDLE.
- bytes_sent  out  CNT_W  count of tx_start pulses.

## Operation
- Write arbitration is combinational; only the pointer is registered.
  - Grant goes to the single valid requester.
  - If both requesters are valid, grant goes to the one not served last.
  - `last` resets to 1, so req0 wins the first tie.
  - `fifo_wr_en = (req0_valid | req1_valid) & ~fifo_full`.
  - `fifo_wr_data` is the granted requester's data.
  - `reqN_ready = grant==N & ~fifo_full`.
  - `last` updates only on an accepted transfer.
- Full: all readies are 0 and no write occurs. A pop in the same cycle does not open a write slot.
- Drain FSM states and transitions:
  - IDLE → POP when `enable & ~fifo_empty`.
  - POP → LOAD unconditionally. `fifo_rd_en` = 1 only in POP.
  - LOAD → WAIT unconditionally. On this edge: `tx_data <= fifo_rd_data`, `tx_start <= 1`, `bytes_sent <= bytes_sent + 1`.
  - WAIT → IDLE on `tx_done_tick`.
- `tx_done_tick` is ignored outside WAIT.
- `tx_start` is registered and high for exactly the first WAIT cycle.
- `bytes_sent` wraps from 2^CNT_W−1 to 0.
- Deasserting `enable` never aborts a byte already past IDLE. The byte completes and the FSM parks in IDLE.
- Simultaneous write and pop are allowed; the FIFO resolves them.
- Reset values: state IDLE, `tx_start` 0, `tx_data` 0, `bytes_sent` 0, `last` 1, `busy` 0. All combinational outputs evaluate to 0 when there are no requests.
- Reset mid-operation: the FSM returns to IDLE and the in-flight byte is dropped (it was already popped). FIFO reset is handled by the FIFO's own reset.

## Timing
- Write latency is 0 cycles from valid && ready to the FIFO write at that edge.
- Drain: `~fifo_empty` sampled in IDLE at cycle 0.
  - Cycle 1: POP (`rd_en`).
  - Cycle 2: LOAD (`fifo_rd_data` valid).
  - Cycle 3: `tx_start` = 1 with `tx_data` valid.
- Minimum byte-to-byte spacing is (done tick cycle) + 4.
- `tx_done_tick` in the same cycle as `tx_start` (first WAIT cycle) is honoured.

## Structure
- Shared package `uart_pkg`:
  - drain state enum (IDLE, POP, LOAD, WAIT);
  - default DBITS.
- Sub-module `rr_arb2`: two-requester round-robin grant with the `last` register. Ports: clk, reset, req[1:0], advance, grant[1:0].

## Test plan
- Reset, then req0_valid with 0x41 for one cycle, enable=1:
  - req0_ready=1 and fifo_wr_en=1 that cycle;
  - tx_start=1 with tx_data=0x41 exactly 3 cycles after fifo_empty falls;
  - bytes_sent=1.
- req0 and req1 both continuously valid (0xA0, 0xB0) for 4 accepted transfers:
  - FIFO write order A0, B0, A0, B0;
  - never two consecutive grants to the same requester.
- Fill FIFO to 16 with enable=0, then req1_valid=1:
  - req1_ready=0 and fifo_wr_en=0;
  - after enable=1 and the first POP, ready returns the cycle after fifo_full falls.
- enable dropped in the POP cycle:
  - byte still reaches tx_start;
  - after tx_done_tick the FSM stays IDLE with the FIFO non-empty;
  - busy=0.
- reset asserted in WAIT: next cycle busy=0, tx_start=0, bytes_sent=0; a tx_done_tick afterwards has no effect.
- 65536 transmitted bytes (CNT_W=16): bytes_sent wraps to 0; a tx_done_tick outside WAIT is ignored.
